// File: rtl/stopwatch_lap_capture.sv
// Lap-capture FIFO for a wrapping stopwatch count; define LAP_DELTA_EN to store
// split times (delta from the previous lap) instead of absolute lap times.
module stopwatch_lap_capture #(
    parameter int DATA_WIDTH = 16,
    parameter int MAX        = 99,
    parameter int DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DATA_WIDTH-1:0]        count,
    input  logic                         lap,
    input  logic                         clear,
    input  logic                         rd_ready,
    output logic                         rd_valid,
    output logic [DATA_WIDTH-1:0]        rd_data,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         full,
    output logic                         empty,
    output logic                         overflow
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH + 1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || MAX < 0 ||
        longint'(MAX) >= (longint'(1) << DATA_WIDTH)) begin : g_param_check
        $error("stopwatch_lap_capture: DEPTH must be a power of two >= 2 and MAX must fit DATA_WIDTH");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [LW-1:0]         level_q;
    logic                  overflow_q;
    logic                  pop;
    logic                  push;
    logic [DATA_WIDTH-1:0] entry;

    // Handshake: the head entry transfers on a rising edge where rd_valid and
    // rd_ready are both high; rd_data is valid combinationally whenever rd_valid is.
    assign empty    = (level_q == '0);
    assign full     = (level_q == LW'(DEPTH));
    assign rd_valid = !empty;
    assign rd_data  = mem[rd_ptr];
    assign level    = level_q;
    assign overflow = overflow_q;

    assign pop  = rd_valid && rd_ready;
    assign push = lap && (!full || pop);

`ifdef LAP_DELTA_EN
    localparam logic [DATA_WIDTH-1:0] SPAN = DATA_WIDTH'(MAX + 1);

    logic [DATA_WIDTH-1:0] prev_q;

    // A count below the reference means the stopwatch wrapped since the last lap.
    always_comb begin
        entry = count - prev_q;
        if (count < prev_q) begin
            entry = count + SPAN - prev_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q <= '0;
        end else if (clear) begin
            prev_q <= '0;
        end else if (lap) begin
            prev_q <= count;
        end
    end
`else
    always_comb begin
        entry = count;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
            if (lap && !push) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Storage is not reset; a stray write during reset lands in discarded space.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= entry;
        end
    end

endmodule

// File: tb/tb_stopwatch_lap_capture.sv
// Directed bench for stopwatch_lap_capture: stimulus pushes hand-computed
// entries into exp_q, a negedge monitor pops and compares on each transfer.
module tb_stopwatch_lap_capture;

    localparam int DW    = 16;
    localparam int MAX   = 99;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] count = '0;
    logic          lap = 1'b0;
    logic          clear = 1'b0;
    logic          rd_ready = 1'b0;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic [LW-1:0] level;
    logic          full;
    logic          empty;
    logic          overflow;

    logic [DW-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    stopwatch_lap_capture #(.DATA_WIDTH(DW), .MAX(MAX), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .count    (count),
        .lap      (lap),
        .clear    (clear),
        .rd_ready (rd_ready),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .level    (level),
        .full     (full),
        .empty    (empty),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One accepted lap: drive count, expect `exp_val` to be stored.
    task automatic do_lap(input logic [DW-1:0] c, input logic [DW-1:0] exp_val, input bit accepted);
        count = c;
        lap   = 1'b1;
        if (accepted) exp_q.push_back(exp_val);
        tick();
        lap = 1'b0;
    endtask

    task automatic drain(input int n);
        rd_ready = 1'b1;
        repeat (n) tick();
        rd_ready = 1'b0;
    endtask

    // Monitor: a transfer happens at the next edge when valid & ready and no flush.
    always @(negedge clk) begin
        if (!reset && !clear && rd_valid && rd_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pop: got %0d expected none", rd_data);
            end else begin
                check("rd_data", rd_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #12;
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_valid", rd_valid, 0);
        check("rst_level", level, 0);
        check("rst_overflow", overflow, 0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Three laps then drain in order
        do_lap(10, 10, 1);
`ifdef LAP_DELTA_EN
        do_lap(25, 15, 1);
        do_lap(40, 15, 1);
`else
        do_lap(25, 25, 1);
        do_lap(40, 40, 1);
`endif
        check("level3", level, 3);
        drain(3);
        check("empty_after_drain", empty, 1);

        // Flush, then overfill: fifth lap dropped
        clear = 1'b1;
        tick();
        clear = 1'b0;
`ifdef LAP_DELTA_EN
        do_lap(1, 1, 1);
        do_lap(2, 1, 1);
        do_lap(3, 1, 1);
        do_lap(4, 1, 1);
`else
        do_lap(1, 1, 1);
        do_lap(2, 2, 1);
        do_lap(3, 3, 1);
        do_lap(4, 4, 1);
`endif
        check("ovf_before_drop", overflow, 0);
        do_lap(5, 0, 0);
        check("full", full, 1);
        check("level_full", level, 4);
        check("overflow_set", overflow, 1);

        // Full with same-edge pop: lap at 7 accepted
        rd_ready = 1'b1;
`ifdef LAP_DELTA_EN
        do_lap(7, 2, 1);
`else
        do_lap(7, 7, 1);
`endif
        rd_ready = 1'b0;
        check("level_pushpop_full", level, 4);
        check("overflow_sticky", overflow, 1);
        drain(4);
        check("empty_after_full", empty, 1);
        check("overflow_after_drain", overflow, 1);

        // Level 2, then clear with lap and rd_ready
`ifdef LAP_DELTA_EN
        do_lap(30, 23, 1);
        do_lap(35, 5, 1);
`else
        do_lap(30, 30, 1);
        do_lap(35, 35, 1);
`endif
        check("level2", level, 2);
        clear    = 1'b1;
        lap      = 1'b1;
        rd_ready = 1'b1;
        count    = 50;
        tick();
        exp_q.delete();
        clear    = 1'b0;
        lap      = 1'b0;
        rd_ready = 1'b0;
        check("clear_level", level, 0);
        check("clear_empty", empty, 1);
        check("clear_overflow", overflow, 0);
        do_lap(20, 20, 1);
        check("level_after_clear", level, 1);
        drain(1);

        // Wrap-around split
`ifdef LAP_DELTA_EN
        do_lap(95, 75, 1);
        do_lap(3, 8, 1);
`else
        do_lap(95, 95, 1);
        do_lap(3, 3, 1);
`endif
        drain(2);

        // Pop while empty is ignored
        rd_ready = 1'b1;
        tick();
        tick();
        rd_ready = 1'b0;
        check("no_underflow", level, 0);

        // Push and pop at level 1: new entry becomes head
`ifdef LAP_DELTA_EN
        do_lap(60, 57, 1);
        rd_ready = 1'b1;
        do_lap(70, 10, 1);
`else
        do_lap(60, 60, 1);
        rd_ready = 1'b1;
        do_lap(70, 70, 1);
`endif
        rd_ready = 1'b0;
        check("level_pushpop_1", level, 1);
        drain(1);

        // Asynchronous reset mid-cycle with level 3
        do_lap(11, 0, 0);
        do_lap(12, 0, 0);
        do_lap(13, 0, 0);
        check("level_pre_reset", level, 3);
        #3;
        reset = 1'b1;
        #1;
        check("async_empty", empty, 1);
        check("async_level", level, 0);
        check("async_valid", rd_valid, 0);
        exp_q.delete();
        tick();
        reset = 1'b0;
        tick();
        check("post_reset_empty", empty, 1);

        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stopwatch_lap_capture.md
STOPWATCH_LAP_CAPTURE -- requirements
Module: stopwatch_lap_capture

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of the stopwatch count and of stored lap entries.
REQ-002 Parameter MAX, default 99: terminal count of the upstream stopwatch, after which it wraps to 0.
REQ-003 Parameter DEPTH, default 4: lap FIFO entries; power of two, at least 2.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 count  input  DATA_WIDTH  live stopwatch count, range 0..MAX.
REQ-007 lap  input  1  capture request, sampled on each rising edge; one capture per high cycle.
REQ-008 clear  input  1  synchronous flush.
REQ-009 rd_ready  input  1  consumer accepts the head entry.
REQ-010 rd_valid  output  1  head entry present.
REQ-011 rd_data  output  DATA_WIDTH  head entry value.
REQ-012 level  output  $clog2(DEPTH+1)  number of stored entries.
REQ-013 full  output  1  high when level equals DEPTH.
REQ-014 empty  output  1  high when level equals 0.
REQ-015 overflow  output  1  sticky flag: a lap was dropped.

Function
REQ-016 rd_valid SHALL equal not empty, and rd_data SHALL be the oldest entry, driven combinationally from storage with no read latency.
REQ-017 Pop SHALL occur on an edge where rd_valid and rd_ready are both high; the next entry SHALL appear on rd_data in the following cycle.
REQ-018 Push SHALL occur on an edge where lap is high and either (level < DEPTH) or a pop occurs on the same edge; the entry is the value computed from count at that edge.
REQ-019 Simultaneous push and pop SHALL leave level unchanged, including at full; when level is 1, the new entry becomes the head.
REQ-020 A lap with the FIFO full and no same-edge pop SHALL be dropped and SHALL set overflow on that edge.
REQ-021 overflow SHALL remain set until clear or reset.
REQ-022 clear SHALL have priority over lap and pop on the same edge: level, overflow and the previous-lap reference SHALL go to 0, and nothing is pushed.
REQ-023 A pop with rd_valid low SHALL be ignored, and the level SHALL never underflow or exceed DEPTH.
REQ-024 The read and write pointers SHALL wrap modulo DEPTH.
REQ-025 A previous-lap reference register, DATA_WIDTH bits, SHALL load count on every edge where lap is high and clear is low, whether the lap is accepted or dropped.

Reset
REQ-026 While reset is high, the block SHALL immediately force: level 0, pointers 0, previous-lap reference 0, overflow 0.
REQ-027 As a result of REQ-026, reset SHALL force empty = 1, full = 0 and rd_valid = 0, and all stored entries SHALL be discarded.
REQ-028 Reset asserted mid-operation SHALL discard any push or pop on that edge.
REQ-029 Storage contents are not reset, and rd_data is don't-care while empty.

Configuration
REQ-030 Macro LAP_DELTA_EN defined: each stored entry SHALL be the split time, prev being the previous-lap reference value:
  - count - prev when count >= prev;
  - otherwise count + (MAX+1) - prev (wrap-around).
REQ-031 Macro LAP_DELTA_EN not defined: each stored entry SHALL be count unchanged (absolute lap time), and the previous-lap reference register may be omitted.

Verification
REQ-032 After reset, push laps at count 10, 25 and 40 with rd_ready=0, then hold rd_ready=1 -> level 3, then rd_data 10, 25, 40 on successive cycles (delta build: 10, 15, 15), then empty=1.
REQ-033 Apply DEPTH+1 laps (count 1..5) with rd_ready=0 -> full=1, level=4, overflow=1 after the fifth lap, stored entries 1..4; then hold rd_ready=1 -> 1, 2, 3, 4 out.
REQ-034 With the FIFO full and overflow=1, hold lap=1 and rd_ready=1 for one cycle at count 7 -> level stays 4, head advances, entry 7 is appended at the tail, overflow stays 1.
REQ-035 LAP_DELTA_EN defined, MAX=99: lap at count 95, then lap at count 3 -> second entry = 8 (wrap-around).
REQ-036 Assert clear together with lap and rd_ready while level 2 and overflow=1 -> next cycle level 0, empty=1, overflow=0, no entry pushed; a following lap at count 20 stores 20 in both configurations.
REQ-037 Assert reset asynchronously between clock edges with level 3 -> empty=1, level=0 and rd_valid=0 immediately, before the next edge.
